// File: rtl/acgen_mp_if.sv
// Beat interface for the multi-lane JPEG-LS neighbour generator:
// the pixel input stream in, the current samples and their a/b/c/d neighbours out.
interface acgen_mp_if #(
    parameter int BW    = 8,
    parameter int LANES = 8
);
    localparam int W = LANES * BW;

    logic         ena;
    logic         i_vl;
    logic         i_sl;
    logic         i_sp;
    logic         i_el;
    logic [W-1:0] i_x;
    logic         o_vl;
    logic         o_sp;
    logic         o_el;
    logic         o_err;
    logic [W-1:0] o_x;
    logic [W-1:0] o_a;
    logic [W-1:0] o_b;
    logic [W-1:0] o_c;
    logic [W-1:0] o_d;

    modport master (
        output ena, i_vl, i_sl, i_sp, i_el, i_x,
        input  o_vl, o_sp, o_el, o_err, o_x, o_a, o_b, o_c, o_d
    );

    modport slave (
        input  ena, i_vl, i_sl, i_sp, i_el, i_x,
        output o_vl, o_sp, o_el, o_err, o_x, o_a, o_b, o_c, o_d
    );
endinterface

// File: rtl/acgen_mp.sv
// Multi-lane JPEG-LS context generator: keeps the previous row in a line buffer
// and emits per-lane a/b/c/d neighbours one registered stage after each beat.
module acgen_mp #(
    parameter int BW    = 8,
    parameter int LANES = 8,
    parameter int MAXW  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    acgen_mp_if.slave   bus
);
    localparam int NB = MAXW / LANES;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int W  = LANES * BW;

    logic [W-1:0]  mem [NB];
    logic [KW-1:0] k;
    logic          fl;
    logic          ovf;
    logic [BW-1:0] startb;
    logic [BW-1:0] prevx;
    logic [BW-1:0] prevb;

    logic          r_vl, r_sp, r_el, r_err;
    logic [W-1:0]  r_x, r_a, r_b, r_c, r_d;

    logic          acc, sp, fl_e, ovf_e;
    logic [KW-1:0] ke, kn;
    logic [W-1:0]  row_k;
    logic [BW-1:0] row_n0;
    logic [BW-1:0] sb_e;
    logic [W-1:0]  a_n, b_n, c_n, d_n;

    always_comb begin
        acc    = bus.ena & bus.i_vl;
        sp     = bus.i_sp | bus.i_sl;
        ke     = sp ? '0 : k;
        ovf_e  = ovf & ~sp;
        fl_e   = fl | bus.i_sl;
        kn     = (ke == KW'(NB - 1)) ? '0 : ke + 1'b1;
        // Row above is meaningless on the first line and past an overflow.
        row_k  = (fl_e | ovf_e) ? '0 : mem[ke];
        row_n0 = ovf_e ? '0 : mem[kn][BW-1:0];
        sb_e   = bus.i_sl ? '0 : startb;
    end

    always_comb begin
        a_n = '0;
        b_n = row_k;
        c_n = '0;
        d_n = '0;
        a_n[BW-1:0] = sp ? row_k[BW-1:0] : prevx;
        c_n[BW-1:0] = sp ? sb_e : prevb;
        for (int i = 1; i < LANES; i++) begin
            a_n[i*BW +: BW] = bus.i_x[(i-1)*BW +: BW];
            c_n[i*BW +: BW] = row_k[(i-1)*BW +: BW];
        end
        for (int i = 0; i < LANES - 1; i++) begin
            d_n[i*BW +: BW] = row_k[(i+1)*BW +: BW];
        end
        d_n[(LANES-1)*BW +: BW] = (bus.i_el | fl_e) ? row_k[(LANES-1)*BW +: BW] : row_n0;
    end

    always_ff @(posedge clk) begin
        if (acc && !ovf_e) begin
            mem[ke] <= bus.i_x;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vl   <= 1'b0;
            r_sp   <= 1'b0;
            r_el   <= 1'b0;
            r_err  <= 1'b0;
            r_x    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_d    <= '0;
            k      <= '0;
            fl     <= 1'b1;
            ovf    <= 1'b0;
            startb <= '0;
            prevx  <= '0;
            prevb  <= '0;
        end else if (bus.ena) begin
            r_vl <= bus.i_vl;
            if (bus.i_vl) begin
                r_sp  <= sp;
                r_el  <= bus.i_el;
                r_x   <= bus.i_x;
                r_a   <= a_n;
                r_b   <= b_n;
                r_c   <= c_n;
                r_d   <= d_n;
                prevx <= bus.i_x[(LANES-1)*BW +: BW];
                prevb <= row_k[(LANES-1)*BW +: BW];
                if (sp) begin
                    startb <= row_k[BW-1:0];
                end
                if (bus.i_sl) begin
                    r_err <= 1'b0;
                end else if (ovf_e) begin
                    r_err <= 1'b1;
                end
                fl <= bus.i_el ? 1'b0 : fl_e;
                // A non-el beat in the last slot fills the line; any further beat overflows.
                if (bus.i_el) begin
                    k   <= '0;
                    ovf <= 1'b0;
                end else if (ke == KW'(NB - 1)) begin
                    k   <= ke;
                    ovf <= 1'b1;
                end else begin
                    k   <= ke + 1'b1;
                    ovf <= 1'b0;
                end
            end
        end
    end

    assign bus.o_vl  = r_vl;
    assign bus.o_sp  = r_sp;
    assign bus.o_el  = r_el;
    assign bus.o_err = r_err;
    assign bus.o_x   = r_x;
    assign bus.o_a   = r_a;
    assign bus.o_b   = r_b;
    assign bus.o_c   = r_c;
    assign bus.o_d   = r_d;
endmodule

// File: tb/tb_acgen_mp.sv
// Directed bench for acgen_mp at LANES=4, BW=8, MAXW=16 (four beats per line).
module tb_acgen_mp;
    localparam int BW    = 8;
    localparam int LANES = 4;
    localparam int MAXW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    acgen_mp_if #(.BW(BW), .LANES(LANES)) bus ();
    acgen_mp #(.BW(BW), .LANES(LANES), .MAXW(MAXW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        ena, vl, sl, sp, el;
        logic [31:0] x;
        logic        e_vl, e_sp, e_el, e_err;
        logic [31:0] e_x, e_a, e_b, e_c, e_d;
        logic        chk_data;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] p(int a0, int a1, int a2, int a3);
        logic [7:0] b0, b1, b2, b3;
        b0 = a0[7:0]; b1 = a1[7:0]; b2 = a2[7:0]; b3 = a3[7:0];
        return {b3, b2, b1, b0};
    endfunction

    task automatic add(input logic ena, vl, sl, sp, el, input logic [31:0] x,
                       input logic e_vl, e_sp, e_el, e_err,
                       input logic [31:0] e_x, e_a, e_b, e_c, e_d, input logic chk_data);
        vec_t v;
        v.ena = ena; v.vl = vl; v.sl = sl; v.sp = sp; v.el = el; v.x = x;
        v.e_vl = e_vl; v.e_sp = e_sp; v.e_el = e_el; v.e_err = e_err;
        v.e_x = e_x; v.e_a = e_a; v.e_b = e_b; v.e_c = e_c; v.e_d = e_d;
        v.chk_data = chk_data;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic ena, vl, sl, sp, el, input logic [31:0] x);
        bus.ena = ena; bus.i_vl = vl; bus.i_sl = sl; bus.i_sp = sp; bus.i_el = el; bus.i_x = x;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".vl"},  32'(bus.o_vl),  32'd0);
        chk({tag, ".err"}, 32'(bus.o_err), 32'd0);
        chk({tag, ".x"},   bus.o_x, 32'd0);
        chk({tag, ".a"},   bus.o_a, 32'd0);
        chk({tag, ".b"},   bus.o_b, 32'd0);
        chk({tag, ".c"},   bus.o_c, 32'd0);
        chk({tag, ".d"},   bus.o_d, 32'd0);
    endtask

    initial begin
        logic [31:0] z;
        logic [31:0] b4;
        z = 32'd0;
        // line 1 (first line)
        add(1,1,1,1,0, p(1,2,3,4),    1,1,0,0, p(1,2,3,4),    p(0,1,2,3),     z, z, z, 1);
        add(1,1,0,0,1, p(5,6,7,8),    1,0,1,0, p(5,6,7,8),    p(4,5,6,7),     z, z, z, 1);
        add(1,0,0,0,0, z,             0,0,0,0, z, z, z, z, z, 0);
        // line 2
        add(1,1,0,1,0, p(9,10,11,12), 1,1,0,0, p(9,10,11,12), p(1,9,10,11),
            p(1,2,3,4), p(0,1,2,3), p(2,3,4,5), 1);
        add(1,1,0,0,1, p(13,14,15,16),1,0,1,0, p(13,14,15,16),p(12,13,14,15),
            p(5,6,7,8), p(4,5,6,7), p(6,7,8,8), 1);
        // line 3
        add(1,1,0,1,0, p(17,18,19,20),1,1,0,0, p(17,18,19,20),p(9,17,18,19),
            p(9,10,11,12), p(1,9,10,11), p(10,11,12,13), 1);
        add(1,1,0,0,1, p(21,22,23,24),1,0,1,0, p(21,22,23,24),p(20,21,22,23),
            p(13,14,15,16), p(12,13,14,15), p(14,15,16,16), 1);
        // line 4 with a 3-cycle stall between beats
        b4 = p(9,10,11,12);
        add(1,1,0,1,0, b4,            1,1,0,0, b4, p(17,9,10,11),
            p(17,18,19,20), p(9,17,18,19), p(18,19,20,21), 1);
        for (int i = 0; i < 3; i++)
            add(0,1,0,0,1, p(99,98,97,96), 1,1,0,0, b4, p(17,9,10,11),
                p(17,18,19,20), p(9,17,18,19), p(18,19,20,21), 1);
        add(1,1,0,0,1, p(13,14,15,16),1,0,1,0, p(13,14,15,16),p(12,13,14,15),
            p(21,22,23,24), p(20,21,22,23), p(22,23,24,24), 1);
        // line 5 confirms the stall wrote nothing
        add(1,1,0,1,0, p(1,1,1,1),    1,1,0,0, p(1,1,1,1),    p(9,1,1,1),
            p(9,10,11,12), p(17,9,10,11), p(10,11,12,13), 1);
        add(1,1,0,0,1, p(2,2,2,2),    1,0,1,0, p(2,2,2,2),    p(1,2,2,2),
            p(13,14,15,16), p(12,13,14,15), p(14,15,16,16), 1);
        // overflow: new image, five beats then a late el
        add(1,1,1,1,0, p(10,11,12,13),1,1,0,0, p(10,11,12,13),p(0,10,11,12), z, z, z, 1);
        add(1,1,0,0,0, p(20,21,22,23),1,0,0,0, p(20,21,22,23),p(13,20,21,22), z, z, z, 1);
        add(1,1,0,0,0, p(30,31,32,33),1,0,0,0, p(30,31,32,33),p(23,30,31,32), z, z, z, 1);
        add(1,1,0,0,0, p(40,41,42,43),1,0,0,0, p(40,41,42,43),p(33,40,41,42), z, z, z, 1);
        add(1,1,0,0,0, p(50,51,52,53),1,0,0,1, p(50,51,52,53),p(43,50,51,52), z, z, z, 1);
        add(1,1,0,0,1, p(60,61,62,63),1,0,1,1, p(60,61,62,63),p(53,60,61,62), z, z, z, 1);
        // next line reads back beats 0..3; beat 3 must still hold the 4th beat
        add(1,1,0,1,0, p(1,2,3,4),    1,1,0,1, p(1,2,3,4),    p(10,1,2,3),
            p(10,11,12,13), p(0,10,11,12), p(11,12,13,20), 1);
        add(1,1,0,0,0, p(5,6,7,8),    1,0,0,1, p(5,6,7,8),    p(4,5,6,7),
            p(20,21,22,23), p(13,20,21,22), p(21,22,23,30), 1);
        add(1,1,0,0,0, p(9,10,11,12), 1,0,0,1, p(9,10,11,12), p(8,9,10,11),
            p(30,31,32,33), p(23,30,31,32), p(31,32,33,40), 1);
        add(1,1,0,0,1, p(13,14,15,16),1,0,1,1, p(13,14,15,16),p(12,13,14,15),
            p(40,41,42,43), p(33,40,41,42), p(41,42,43,43), 1);
        // i_sl clears the error
        add(1,1,1,1,0, p(7,7,7,7),    1,1,0,0, p(7,7,7,7),    p(0,7,7,7), z, z, z, 1);
        add(1,1,0,0,1, p(8,8,8,8),    1,0,1,0, p(8,8,8,8),    p(7,8,8,8), z, z, z, 1);

        drive(0,0,0,0,0, z);
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[n]) begin
            string t;
            t = $sformatf("v%0d", n);
            drive(vq[n].ena, vq[n].vl, vq[n].sl, vq[n].sp, vq[n].el, vq[n].x);
            @(posedge clk);
            #1;
            chk({t, ".vl"}, 32'(bus.o_vl), 32'(vq[n].e_vl));
            if (vq[n].chk_data) begin
                chk({t, ".sp"},  32'(bus.o_sp),  32'(vq[n].e_sp));
                chk({t, ".el"},  32'(bus.o_el),  32'(vq[n].e_el));
                chk({t, ".err"}, 32'(bus.o_err), 32'(vq[n].e_err));
                chk({t, ".x"},   bus.o_x, vq[n].e_x);
                chk({t, ".a"},   bus.o_a, vq[n].e_a);
                chk({t, ".b"},   bus.o_b, vq[n].e_b);
                chk({t, ".c"},   bus.o_c, vq[n].e_c);
                chk({t, ".d"},   bus.o_d, vq[n].e_d);
            end
        end

        // async reset mid-line, then the next line must look like a first line
        drive(1,1,0,1,0, p(1,2,3,4));
        @(posedge clk);
        #1;
        chk("mid.vl", 32'(bus.o_vl), 32'd1);
        chk("mid.b",  bus.o_b, p(7,7,7,7));
        drive(1,0,0,0,0, z);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("arst");
        @(negedge clk);
        rst = 1'b0;
        drive(1,1,0,1,0, p(5,5,5,5));
        @(posedge clk);
        #1;
        chk("post0.vl", 32'(bus.o_vl), 32'd1);
        chk("post0.a",  bus.o_a, p(0,5,5,5));
        chk("post0.b",  bus.o_b, z);
        chk("post0.c",  bus.o_c, z);
        chk("post0.d",  bus.o_d, z);
        drive(1,1,0,0,1, p(6,6,6,6));
        @(posedge clk);
        #1;
        chk("post1.a",  bus.o_a, p(5,6,6,6));
        chk("post1.b",  bus.o_b, z);
        chk("post1.c",  bus.o_c, z);
        chk("post1.d",  bus.o_d, z);
        chk("post1.el", 32'(bus.o_el), 32'd1);
        drive(0,0,0,0,0, z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
